// File: rtl/mem_arbiter_pkg.sv
// Shared requester IDs and transfer-size encodings for the memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned SIZE_W = 2;

    // Requester IDs stored in the in-order tag FIFO.
    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    // log2 of the byte count carried on *_size.
    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_arbiter_arb_id_fifo.sv
// In-order 1-bit requester-ID FIFO; full/empty derive from the registered count.
module arb_id_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Next-state: write at tail, advance pointers (wrap is natural for power-of-two DEPTH), track count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers, cleared immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one sram-like memory port.
// Optional build macro ARB_RR_EN: round-robin grant instead of fixed data priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch side
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    // load/store side
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [SIZE_W-1:0] data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [STRB_W-1:0] data_wstrb,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    // shared memory port
    output logic              mem_req,
    output logic              mem_wr,
    output logic [SIZE_W-1:0] mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic grant_q, grant_d;
    logic lock_q, lock_d;
    logic fifo_full, fifo_empty, fifo_head;
    logic handshake, resp_valid;
    logic gnt_req;
`ifdef ARB_RR_EN
    logic rr_q, rr_d;
`endif

    // Grant: held while locked, otherwise arbitrated among current requests.
    always_comb begin
        grant_d = grant_q;
        if (!lock_q) begin
`ifdef ARB_RR_EN
            if (data_req && inst_req) begin
                grant_d = (rr_q == ID_INST) ? ID_DATA : ID_INST;
            end else if (inst_req) begin
                grant_d = ID_INST;
            end else begin
                grant_d = ID_DATA;
            end
`else
            grant_d = (inst_req && !data_req) ? ID_INST : ID_DATA;
`endif
        end
    end

    // Memory-port mux and handshake routing; everything is suppressed during reset.
    always_comb begin
        gnt_req      = (grant_d == ID_DATA) ? data_req : inst_req;
        mem_req      = gnt_req & ~fifo_full & ~rst;
        handshake    = mem_req & mem_addr_ok;
        inst_addr_ok = handshake & (grant_d == ID_INST);
        data_addr_ok = handshake & (grant_d == ID_DATA);
        if (grant_d == ID_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
            mem_wstrb = data_wstrb;
        end else begin
            mem_wr    = 1'b0;
            mem_size  = SIZE_WORD;
            mem_addr  = inst_addr;
            mem_wdata = '0;
            mem_wstrb = '0;
        end
        resp_valid   = mem_data_ok & ~fifo_empty & ~rst;
        inst_data_ok = resp_valid & (fifo_head == ID_INST);
        data_data_ok = resp_valid & (fifo_head == ID_DATA);
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
        // An offered but unaccepted request pins the grant for the next cycle.
        lock_d       = mem_req & ~mem_addr_ok;
    end

`ifdef ARB_RR_EN
    // Round-robin pointer remembers the most recently accepted requester.
    always_comb begin
        rr_d = rr_q;
        if (handshake) begin
            rr_d = grant_d;
        end
    end
`endif

    // Arbitration state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= ID_DATA;
            lock_q  <= 1'b0;
`ifdef ARB_RR_EN
            rr_q    <= ID_INST;
`endif
        end else begin
            grant_q <= grant_d;
            lock_q  <= lock_d;
`ifdef ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // Outstanding-request tags, returned in order.
    arb_id_fifo #(
        .DEPTH(DEPTH)
    ) u_id_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (handshake),
        .push_id(grant_d),
        .pop    (resp_valid),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (DEPTH=4).
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_wstrb  (data_wstrb),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_size    (mem_size),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd2;
        data_wstrb  = 4'h0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
    endtask

    // Check which side, if any, sees data_ok this cycle (0=inst, 1=data, 2=none).
    task automatic check_resp(input string tag, input int who);
        check({tag, "_inst_dok"}, 32'(inst_data_ok), 32'(who == 0));
        check({tag, "_data_dok"}, 32'(data_data_ok), 32'(who == 1));
    endtask

    initial begin
        int exp_id [4];
        inst_addr = 32'h0000_1000;
        data_addr = 32'h0000_2000;
        mem_rdata = 32'hDEAD_BEEF;
        idle();

        // Reset with every request line active: all handshake outputs stay low.
        rst         = 1'b1;
        inst_req    = 1'b1;
        data_req    = 1'b1;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        #3;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_inst_aok", 32'(inst_addr_ok), 32'd0);
        check("rst_data_aok", 32'(data_addr_ok), 32'd0);
        check_resp("rst", 2);
        tick();
        tick();
        rst = 1'b0;
        idle();

        // Both request with empty FIFO: data wins, then its response comes back.
        inst_req    = 1'b1;
        data_req    = 1'b1;
        mem_addr_ok = 1'b1;
        #1;
        check("both_data_aok", 32'(data_addr_ok), 32'd1);
        check("both_inst_aok", 32'(inst_addr_ok), 32'd0);
        check("both_mem_addr", mem_addr, 32'h0000_2000);
        tick();
        idle();
        mem_data_ok = 1'b1;
        #1;
        check_resp("both_resp", 1);
        check("both_rdata", data_rdata, 32'hDEAD_BEEF);
        tick();
        // Response with empty FIFO is ignored.
        #1;
        check_resp("empty_resp", 2);
        tick();
        idle();

        // Fetch stalled three cycles; data request arriving mid-stall must wait.
        inst_req = 1'b1;
        #1;
        check("lock_c0_addr", mem_addr, 32'h0000_1000);
        check("lock_c0_size", 32'(mem_size), 32'd2);
        check("lock_c0_wr", 32'(mem_wr), 32'd0);
        check("lock_c0_wstrb", 32'(mem_wstrb), 32'd0);
        tick();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd1;
        data_wstrb = 4'b0011;
        data_wdata = 32'h0000_A5A5;
        #1;
        check("lock_c1_addr", mem_addr, 32'h0000_1000);
        check("lock_c1_data_aok", 32'(data_addr_ok), 32'd0);
        tick();
        #1;
        check("lock_c2_addr", mem_addr, 32'h0000_1000);
        tick();
        mem_addr_ok = 1'b1;
        #1;
        check("lock_c3_inst_aok", 32'(inst_addr_ok), 32'd1);
        check("lock_c3_addr", mem_addr, 32'h0000_1000);
        tick();
        inst_req = 1'b0;
        #1;
        check("after_data_aok", 32'(data_addr_ok), 32'd1);
        check("after_mem_wr", 32'(mem_wr), 32'd1);
        check("after_mem_size", 32'(mem_size), 32'd1);
        check("after_mem_wstrb", 32'(mem_wstrb), 32'h3);
        check("after_mem_wdata", mem_wdata, 32'h0000_A5A5);
        tick();
        idle();
        mem_data_ok = 1'b1;
        #1;
        check_resp("lock_r0", 0);
        tick();
        #1;
        check_resp("lock_r1", 1);
        tick();
        idle();

        // Fill the four-entry FIFO with fetches; fifth is blocked until a pop lands.
        inst_req    = 1'b1;
        mem_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("fill_aok%0d", i), 32'(inst_addr_ok), 32'd1);
            tick();
        end
        #1;
        check("full_mem_req", 32'(mem_req), 32'd0);
        check("full_inst_aok", 32'(inst_addr_ok), 32'd0);
        mem_data_ok = 1'b1;
        #1;
        check_resp("full_pop", 0);
        check("full_pop_mem_req", 32'(mem_req), 32'd0);
        tick();
        mem_data_ok = 1'b0;
        #1;
        check("refill_mem_req", 32'(mem_req), 32'd1);
        check("refill_inst_aok", 32'(inst_addr_ok), 32'd1);
        tick();
        idle();
        mem_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_resp($sformatf("drain%0d", i), 0);
            tick();
        end
        idle();

        // Accept inst, data, inst; responses must route back in the same order.
        mem_addr_ok = 1'b1;
        inst_req    = 1'b1;
        #1;
        check("ord_a0", 32'(inst_addr_ok), 32'd1);
        tick();
        inst_req = 1'b0;
        data_req = 1'b1;
        #1;
        check("ord_a1", 32'(data_addr_ok), 32'd1);
        tick();
        data_req = 1'b0;
        inst_req = 1'b1;
        #1;
        check("ord_a2", 32'(inst_addr_ok), 32'd1);
        tick();
        idle();
        mem_data_ok = 1'b1;
        #1;
        check_resp("ord_r0", 0);
        tick();
        #1;
        check_resp("ord_r1", 1);
        tick();
        #1;
        check_resp("ord_r2", 0);
        tick();
        idle();

        // Both requests held with immediate accept: grant sequence depends on the build.
`ifdef ARB_RR_EN
        exp_id = '{1, 0, 1, 0};
`else
        exp_id = '{1, 1, 1, 1};
`endif
        inst_req    = 1'b1;
        data_req    = 1'b1;
        mem_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("arb%0d_data_aok", i), 32'(data_addr_ok), 32'(exp_id[i] == 1));
            check($sformatf("arb%0d_inst_aok", i), 32'(inst_addr_ok), 32'(exp_id[i] == 0));
            tick();
        end
        idle();
        mem_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_resp($sformatf("arb_r%0d", i), exp_id[i]);
            tick();
        end
        idle();

        // Reset with two outstanding fetches discards them.
        inst_req    = 1'b1;
        mem_addr_ok = 1'b1;
        tick();
        tick();
        idle();
        rst = 1'b1;
        #1;
        mem_data_ok = 1'b1;
        #1;
        check_resp("mid_rst", 2);
        tick();
        rst = 1'b0;
        #1;
        check_resp("post_rst", 2);
        tick();
        idle();
        inst_req = 1'b1;
        #1;
        check("post_rst_mem_req", 32'(mem_req), 32'd1);
        tick();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DEPTH, 4, max outstanding accepted-but-unanswered requests; power of two, 2..16.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 inst_req  in  1  instruction-fetch read request; sram-like, read-only.
REQ-005 inst_addr  in  32  fetch physical address.
REQ-006 inst_addr_ok / inst_data_ok  out  1 each  fetch request accepted / fetch data returned.
REQ-007 inst_rdata  out  32  fetch read data.
REQ-008 data_req, data_wr  in  1 each  load/store request; data_wr=1 means write.
REQ-009 data_size  in  2  log2 of byte count: 0, 1 or 2.
REQ-010 data_addr, data_wdata  in  32 each  address / write data.
REQ-011 data_wstrb  in  4  write byte enables.
REQ-012 data_addr_ok / data_data_ok  out  1 each  accept / completion, reads and writes.
REQ-013 data_rdata  out  32  load data.
REQ-014 mem_req, mem_wr  out  1 each; mem_size  out  2; mem_addr, mem_wdata  out  32 each; mem_wstrb  out  4  shared sram-like port.
REQ-015 mem_addr_ok, mem_data_ok  in  1 each; mem_rdata  in  32  shared-port responses.

Function
REQ-016 Shall multiplex the two requesters onto mem_*; exactly one requester, the grant, is selected per cycle.
REQ-017 mem_req shall equal the granted requester's req AND NOT tag-FIFO full; address/size/wr/wstrb/wdata are driven from the grant; a fetch drives mem_wr=0, mem_size=2, mem_wstrb=0.
REQ-018 Granted requester's addr_ok = mem_addr_ok & mem_req; the other's addr_ok = 0; combinational, zero latency.
REQ-019 Grant selection when unlocked: data over inst (fixed priority); inst wins only when data_req=0.
REQ-020 Lock: if mem_req=1 and mem_addr_ok=0, the grant shall be held next cycle regardless of new requests; lock releases in the cycle mem_addr_ok=1.
REQ-021 On each handshake (mem_req & mem_addr_ok) the requester ID shall be pushed into an in-order tag FIFO of depth DEPTH.
REQ-022 mem_data_ok shall be routed to inst_data_ok or data_data_ok per the FIFO head ID and pop the head; rdata to both sides is mem_rdata.
REQ-023 mem_data_ok with FIFO empty shall be ignored: no data_ok asserted, no state change.
REQ-024 Push and pop in the same cycle shall leave count unchanged; full is evaluated on the registered count, so a pop never enables a same-cycle push when full.
REQ-025 Count width $clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-026 Requesters may drop req before addr_ok only if unlocked; the arbiter shall never cancel an accepted request.

Reset
REQ-027 rst asserted: count=0, pointers=0, lock=0, grant=data, RR pointer=inst; all registered state cleared immediately.
REQ-028 During reset mem_req, all addr_ok and all data_ok outputs shall be 0; in-flight responses are discarded.

Configuration
REQ-029 Macro ARB_RR_EN defined: unlocked grant alternates round-robin; after a data handshake inst has priority, after an inst handshake data has priority.
REQ-030 ARB_RR_EN undefined: fixed data priority per REQ-019; RR pointer not instantiated.

Structure
REQ-031 Shared package holds ID_INST=1'b0, ID_DATA=1'b1 and the size encodings.
REQ-032 One sub-module arb_id_fifo: 1-bit-wide, DEPTH-entry synchronous FIFO with push, pop, head, full, empty.

Verification
REQ-033 Both req=1, mem_addr_ok=1, FIFO empty -> data_addr_ok=1, inst_addr_ok=0; next mem_data_ok -> data_data_ok=1.
REQ-034 inst granted, mem_addr_ok=0 for 3 cycles, data_req rises at cycle 1 -> mem_addr stays inst_addr until accept; data granted after.
REQ-035 DEPTH=4, four inst accepts without data_ok -> mem_req=0 on fifth; one mem_data_ok -> mem_req=1 next cycle.
REQ-036 Accept inst, data, inst; return three data_ok -> inst_data_ok, data_data_ok, inst_data_ok in that order.
REQ-037 ARB_RR_EN, both req held, mem_addr_ok=1 -> grants alternate data, inst, data, inst.
REQ-038 rst pulsed with 2 outstanding -> count=0; following mem_data_ok produces no data_ok.
